// File: rtl/fir_out_drain_if.sv
// fir_out_drain_if: stream bundle between the FIR pipeline, the output drain and the sink
//   in_valid/in_data   : full-width FIR results from the pipeline (no backpressure)
//   out_valid/out_ready: valid/ready handshake towards the downstream sink
//   out_data           : rounded and saturated output sample
//   master drives the FIR side and the sink's ready; slave is the drain block
interface fir_out_drain_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/fir_out_drain.sv
// fir_out_drain: rounds/saturates FIR results, buffers them in a FIFO, drains via valid/ready
//   clk, rst   : clock and synchronous active-high reset
//   bus        : slave side of fir_out_drain_if (input stream, output handshake)
//   fill       : current FIFO occupancy
//   overflow   : sticky flag, at least one sample dropped
//   sat_count  : saturating count of clipped samples
//   drop_count : saturating count of dropped samples
//   clr_stats  : clears overflow and both counters, wins over same-cycle events
module fir_out_drain #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 16,
  parameter int SHIFT = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fir_out_drain_if.slave           bus,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [15:0]              sat_count,
  output logic [15:0]              drop_count,
  input  logic                     clr_stats
);
  localparam int AW = $clog2(DEPTH);
  // wide enough that the rounding add cannot wrap and the output limits are representable
  localparam int EW = (IN_W > OUT_W ? IN_W : OUT_W) + 1;
  localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
  localparam logic signed [EW-1:0] MAXV = (EW'(1) << (OUT_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);
  logic signed [EW-1:0]    r;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    sat_ev;
  logic                    s1_valid;
  logic signed [OUT_W-1:0] s1_data;
  logic [OUT_W-1:0]        mem [DEPTH];
  logic [AW-1:0]           wp;
  logic [AW-1:0]           rp;
  logic                    rd;
  logic                    wr;
  logic                    drop;
  always_comb begin
    r = (EW'(bus.in_data) + HALF) >>> SHIFT;
    sat_hi = r > MAXV;
    sat_lo = r < MINV;
    sat_ev = bus.in_valid && (sat_hi || sat_lo);
    rd = bus.out_valid && bus.out_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    wr = s1_valid && (fill < (AW+1)'(DEPTH) || rd);
    drop = s1_valid && !wr;
  end
  assign bus.out_valid = fill != '0;
  assign bus.out_data = bus.out_valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= s1_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      wp <= '0;
      rp <= '0;
      fill <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_data <= sat_hi ? MAXV[OUT_W-1:0] : sat_lo ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      fill <= fill + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      overflow <= 1'b0;
      sat_count <= '0;
      drop_count <= '0;
    end else begin
      overflow <= overflow | drop;
      if (sat_ev && sat_count != '1) sat_count <= sat_count + 1'b1;
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: doc/fir_out_drain.md
Name: fir_out_drain

Overview:
Output-side consumer of the pipelined FIR datapath. Accepts one full-width signed accumulator result per cycle from the free-running FIR pipeline, without backpressure. It rounds and saturates each result to the output sample width, then buffers samples in a small FIFO. Samples leave through a valid/ready handshake to the downstream sink, and the block keeps saturation and drop statistics for software/debug.

Parameters:
IN_W, 26, width of signed FIR accumulator result
OUT_W, 16, width of signed output sample
SHIFT, 10, right-shift (fractional bits discarded), must satisfy 1 <= SHIFT < IN_W
DEPTH, 4, FIFO depth in samples, power of 2, >= 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  FIR result valid this cycle
in_data  input  IN_W  signed FIR result
out_valid  output  1  output sample available
out_ready  input  1  downstream accepts sample
out_data  output  OUT_W  signed rounded/saturated sample
fill  output  clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: at least one sample dropped
sat_count  output  16  saturating count of clipped samples
drop_count  output  16  saturating count of dropped samples
clr_stats  input  1  clears overflow, sat_count, drop_count

Behaviour:
- Reset is synchronous (rst sampled on clk rising edge). Reset values: out_valid=0, out_data=0, fill=0, overflow=0, sat_count=0, drop_count=0. Stage-1 valid=0, FIFO pointers=0.
- Reset mid-operation discards all buffered and in-flight samples. No handshake completes in the reset cycle.
- Stage 1 (registered, 1 cycle): r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits so the add cannot wrap. This is round-half-up toward +inf.
- Saturation: r > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1; r < -2^(OUT_W-1) gives -2^(OUT_W-1). Either case raises a 1-cycle sat event, qualified by in_valid.
- Stage 2 (FIFO write): a valid stage-1 sample is written when fill < DEPTH, or when fill == DEPTH and a read completes in the same cycle.
- Otherwise the stage-2 sample is dropped: overflow is set (sticky) and drop_count increments.
- Read side: out_valid = (fill != 0). out_data = FIFO head, stable while out_valid && !out_ready.
- A transfer occurs when out_valid && out_ready.
- Latency: in_valid at edge N gives out_valid at edge N+2 when the FIFO is empty and the sink is idle.
- fill update: +1 on write only, -1 on read only, unchanged on simultaneous write+read or neither. fill never exceeds DEPTH or goes below 0.
- Pointers wrap modulo DEPTH.
- Read while empty: no effect.
- Counters saturate at 16'hFFFF (no wrap).
- clr_stats: clears overflow, sat_count and drop_count on the next edge. If an event coincides with clr_stats, clr wins and the counter becomes 0.
- clr_stats does not touch FIFO contents.
- Throughput: 1 sample/cycle sustained when out_ready is held high.

Test Plan:
1. Rounding (SHIFT=10, OUT_W=16), out_ready=1:
   - in_data 1536 -> out_data 2
   - -1536 -> -1
   - 512 -> 1
   - -512 -> 0
   - 1023 -> 1
   - each appears exactly 2 cycles after input, sat_count stays 0.
2. Saturation:
   - in_data 33554431 -> out_data 32767, sat_count=1
   - in_data -33554432 -> -32768 with sat_count unchanged (exact fit)
   - in_data -33554433 is out of range (not applied)
   - in_data 33553920 -> 32767 and sat_count=2.
3. Backpressure and full:
   - out_ready=0, 6 consecutive valid inputs 1024..6144 step 1024 -> fill reaches 4
   - samples 5 and 6 dropped: overflow=1, drop_count=2
   - then out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, fill back to 0.
4. Full with simultaneous read:
   - fill=4, out_ready=1 and in stream continuous -> no drops, fill stays 4, outputs in order.
5. Mid-operation reset:
   - fill=3 and a sample in stage 1, assert rst one cycle -> next cycle out_valid=0, fill=0, counters 0
   - input after release emerges 2 cycles later.
6. Stats clear:
   - drop_count=2, sat_count=1, pulse clr_stats in the same cycle as a new drop -> all counters 0 and overflow=0 next cycle
   - buffered samples are still delivered.
